// File: rtl/phase_mag_averager.sv
// phase_mag_averager: block-mean of the computing_cascade result stream.
// Accumulates 2**LOG2_NAVG consecutive (delta_ph, div_mag) results and
// publishes their mean in a valid/ready output register. Overwriting an
// unconsumed mean sets a sticky overrun flag.
// Optional build macro: PHASE_MAG_AVERAGER_ROUND_EN selects round-half-up
// means. The default build truncates, which is floor for both outputs.
module phase_mag_averager #(
  parameter int PH_WIDTH  = 32,
  parameter int MAG_WIDTH = 32,
  parameter int LOG2_NAVG = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_vld,
  input  logic signed [PH_WIDTH-1:0]  delta_ph,
  input  logic        [MAG_WIDTH-1:0] div_mag,
  input  logic                        clear,
  output logic signed [PH_WIDTH-1:0]  avg_ph,
  output logic        [MAG_WIDTH-1:0] avg_mag,
  output logic                        o_vld,
  input  logic                        o_rdy,
  output logic                        overrun,
  output logic        [LOG2_NAVG-1:0] fill
);

  // Accumulators carry LOG2_NAVG guard bits, so a full block never overflows.
  localparam int PH_ACC  = PH_WIDTH + LOG2_NAVG;
  localparam int MAG_ACC = MAG_WIDTH + LOG2_NAVG;

  logic signed [PH_ACC-1:0]    r_ph_acc;
  logic        [MAG_ACC-1:0]   r_mag_acc;
  logic        [LOG2_NAVG-1:0] r_fill;
  logic signed [PH_WIDTH-1:0]  r_avg_ph;
  logic        [MAG_WIDTH-1:0] r_avg_mag;
  logic                        r_o_vld;
  logic                        r_overrun;

  logic signed [PH_ACC-1:0]    w_sum_ph;
  logic        [MAG_ACC-1:0]   w_sum_mag;
  logic signed [PH_ACC-1:0]    w_rnd_ph;
  logic        [MAG_ACC-1:0]   w_rnd_mag;
  logic                        w_last;
  logic                        w_done;

  // The sample is sign-/zero-extended to accumulator width before the add.
  assign w_sum_ph  = r_ph_acc + {{LOG2_NAVG{delta_ph[PH_WIDTH-1]}}, delta_ph};
  assign w_sum_mag = r_mag_acc + {{LOG2_NAVG{1'b0}}, div_mag};

`ifdef PHASE_MAG_AVERAGER_ROUND_EN
  // Half an LSB of the mean, added at accumulator width where it cannot overflow.
  localparam logic signed [PH_ACC-1:0]  RND_PH  = PH_ACC'(2 ** (LOG2_NAVG - 1));
  localparam logic        [MAG_ACC-1:0] RND_MAG = MAG_ACC'(2 ** (LOG2_NAVG - 1));
  assign w_rnd_ph  = w_sum_ph + RND_PH;
  assign w_rnd_mag = w_sum_mag + RND_MAG;
`else
  assign w_rnd_ph  = w_sum_ph;
  assign w_rnd_mag = w_sum_mag;
`endif

  // The last slot of a block is reached when every fill bit is set.
  assign w_last = (r_fill == {LOG2_NAVG{1'b1}});
  // clear beats a completing sample: the sample is dropped and no mean is produced.
  assign w_done = i_vld && !clear && w_last;

  // Accumulate path: add samples, restart on completion, clear or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph_acc  <= '0;
      r_mag_acc <= '0;
      r_fill    <= '0;
    end else if (clear || w_done) begin
      r_ph_acc  <= '0;
      r_mag_acc <= '0;
      r_fill    <= '0;
    end else if (i_vld) begin
      r_ph_acc  <= w_sum_ph;
      r_mag_acc <= w_sum_mag;
      r_fill    <= r_fill + LOG2_NAVG'(1);
    end else begin
      r_ph_acc  <= r_ph_acc;
      r_mag_acc <= r_mag_acc;
      r_fill    <= r_fill;
    end
  end

  // Output register: load means, retire on handshake, flag lost means.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg_ph  <= '0;
      r_avg_mag <= '0;
      r_o_vld   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      r_avg_ph  <= PH_WIDTH'(w_rnd_ph >>> LOG2_NAVG);
      r_avg_mag <= MAG_WIDTH'(w_rnd_mag >> LOG2_NAVG);
      r_o_vld   <= 1'b1;
      // A mean still held without a same-cycle accept is lost.
      if (r_o_vld && !o_rdy) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end else if (r_o_vld && o_rdy) begin
      r_avg_ph  <= r_avg_ph;
      r_avg_mag <= r_avg_mag;
      r_o_vld   <= 1'b0;
      r_overrun <= r_overrun;
    end else begin
      r_avg_ph  <= r_avg_ph;
      r_avg_mag <= r_avg_mag;
      r_o_vld   <= r_o_vld;
      r_overrun <= r_overrun;
    end
  end

  assign avg_ph  = r_avg_ph;
  assign avg_mag = r_avg_mag;
  assign o_vld   = r_o_vld;
  assign overrun = r_overrun;
  assign fill    = r_fill;

endmodule

// File: tb/tb_phase_mag_averager.sv
// Testbench for phase_mag_averager (default parameters, N = 8).
// Directed cases and random traffic are compared every cycle against a
// reference model that keeps the partial block as a list of samples and
// computes means with plain integer division.
module tb_phase_mag_averager;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld;
  logic [31:0] delta_ph;
  logic [31:0] div_mag;
  logic        clear;
  logic [31:0] avg_ph;
  logic [31:0] avg_mag;
  logic        o_vld;
  logic        o_rdy;
  logic        overrun;
  logic [2:0]  fill;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  longint      q_ph[$];
  longint      q_mag[$];
  logic        m_vld;
  logic [31:0] m_ph;
  logic [31:0] m_mag;
  logic        m_ovr;

`ifdef PHASE_MAG_AVERAGER_ROUND_EN
  localparam logic [31:0] EXP_T1_PH = 32'd14;
  localparam logic [31:0] EXP_T2_PH = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_T1_PH = 32'd13;
  localparam logic [31:0] EXP_T2_PH = 32'hFFFF_FFFE;
`endif

  phase_mag_averager dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .delta_ph (delta_ph),
    .div_mag  (div_mag),
    .clear    (clear),
    .avg_ph   (avg_ph),
    .avg_mag  (avg_mag),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .overrun  (overrun),
    .fill     (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Mean of an 8-sample sum: floor division, or round half up when enabled.
  function automatic longint mean8(input longint s);
    longint t;
    longint q;
`ifdef PHASE_MAG_AVERAGER_ROUND_EN
    t = s + 64'sd4;
`else
    t = s;
`endif
    q = t / 64'sd8;
    if ((t % 64'sd8 != 64'sd0) && (t < 64'sd0)) q = q - 64'sd1;
    return q;
  endfunction

  // One clock of stimulus, model update and full output comparison.
  task automatic cyc(input logic v, input logic [31:0] ph, input logic [31:0] mag,
                     input logic clr, input logic rdy, input logic rs);
    longint s_ph;
    longint s_mag;
    logic   done;
    logic [63:0] tmp;
    rst = rs; i_vld = v; delta_ph = ph; div_mag = mag; clear = clr; o_rdy = rdy;
    @(posedge clk);
    done = 1'b0;
    if (rs) begin
      q_ph.delete(); q_mag.delete();
      m_vld = 1'b0; m_ph = 32'd0; m_mag = 32'd0; m_ovr = 1'b0;
    end else begin
      if (clr) begin
        q_ph.delete(); q_mag.delete();
      end else if (v) begin
        q_ph.push_back(longint'($signed(ph)));
        q_mag.push_back(longint'({32'd0, mag}));
        if (q_ph.size() == 8) begin
          s_ph = 64'sd0; s_mag = 64'sd0;
          foreach (q_ph[k]) begin
            s_ph  = s_ph + q_ph[k];
            s_mag = s_mag + q_mag[k];
          end
          done = 1'b1;
          q_ph.delete(); q_mag.delete();
        end
      end
      if (done) begin
        if (m_vld && !rdy) m_ovr = 1'b1;
        m_vld = 1'b1;
        tmp = 64'(mean8(s_ph));
        m_ph = tmp[31:0];
        tmp = 64'(mean8(s_mag));
        m_mag = tmp[31:0];
      end else if (m_vld && rdy) begin
        m_vld = 1'b0;
      end
    end
    #1;
    check("o_vld",   64'(o_vld),   64'(m_vld));
    check("overrun", 64'(overrun), 64'(m_ovr));
    check("fill",    64'(fill),    64'(q_ph.size()));
    check("avg_ph",  64'(avg_ph),  64'(m_ph));
    check("avg_mag", 64'(avg_mag), 64'(m_mag));
  endtask

  initial begin
    rst = 1'b1; i_vld = 1'b0; delta_ph = 32'd0; div_mag = 32'd0; clear = 1'b0; o_rdy = 1'b0;
    m_vld = 1'b0; m_ph = 32'd0; m_mag = 32'd0; m_ovr = 1'b0;

    // Reset state.
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_fill", 64'(fill), 64'd0);

    // Eight back-to-back samples 10..17, magnitude 100.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'(10 + i), 32'd100, 1'b0, 1'b0, 1'b0);
      if (i == 6) check("t1_vld_early", 64'(o_vld), 64'd0);
    end
    check("t1_vld", 64'(o_vld), 64'd1);
    check("t1_ph", 64'(avg_ph), 64'(EXP_T1_PH));
    check("t1_mag", 64'(avg_mag), 64'd100);
    check("t1_fill", 64'(fill), 64'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Negative floor and full-scale magnitude.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, (i == 7) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("t2_ph", 64'(avg_ph), 64'(EXP_T2_PH));
    check("t2_mag", 64'(avg_mag), 64'h0000_0000_FFFF_FFFF);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: two blocks with o_rdy low, then one accept.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, (i < 8) ? 32'd5 : 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
      if (i == 7) begin
        check("t3_ph_a", 64'(avg_ph), 64'd5);
        check("t3_ovr_a", 64'(overrun), 64'd0);
      end
    end
    check("t3_ph_b", 64'(avg_ph), 64'd9);
    check("t3_ovr_b", 64'(overrun), 64'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t3_vld_c", 64'(o_vld), 64'd0);
    check("t3_ovr_c", 64'(overrun), 64'd1);

    // Continuous flow with o_rdy held high.
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, (i < 8) ? 32'd20 : 32'd30, 32'd7, 1'b0, 1'b1, 1'b0);
      if (i == 7) check("t4_ph_a", 64'(avg_ph), 64'd20);
    end
    check("t4_vld_b", 64'(o_vld), 64'd1);
    check("t4_ph_b", 64'(avg_ph), 64'd30);
    check("t4_ovr", 64'(overrun), 64'd0);
    // Completion coinciding with acceptance of a held mean: no overrun.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 32'd40, 32'd7, 1'b0, (i == 7), 1'b0);
    check("t4_ph_c", 64'(avg_ph), 64'd40);
    check("t4_ovr_c", 64'(overrun), 64'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // clear discards a partial block; sparse samples afterwards.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'd1000, 32'd1000, 1'b0, 1'b1, 1'b0);
    check("t5_fill_pre", 64'(fill), 64'd5);
    cyc(1'b1, 32'd1000, 32'd1000, 1'b1, 1'b1, 1'b0);
    check("t5_fill_post", 64'(fill), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'd100, 32'd100, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        cyc(1'b0, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0);
      end
    end
    check("t5_ph", 64'(avg_ph), 64'd100);
    check("t5_vld", 64'(o_vld), 64'd1);
    // clear in the completing cycle suppresses the mean.
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'd55, 32'd55, (i == 7), 1'b1, 1'b0);
    check("t5_clr_win", 64'(o_vld), 64'd0);

    // Reset mid-block with a mean pending.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'd900, 32'd900, 1'b0, 1'b0, 1'b0);
    check("t6_fill4", 64'(fill), 64'd4);
    cyc(1'b1, 32'd900, 32'd900, 1'b0, 1'b0, 1'b1);
    check("t6_rst_ph", 64'(avg_ph), 64'd0);
    check("t6_rst_vld", 64'(o_vld), 64'd0);
    check("t6_rst_fill", 64'(fill), 64'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0);
    check("t6_ph", 64'(avg_ph), 64'd7);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom(), $urandom(),
          ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
